imem_loader: RTL and testbench

- Writer side of the instruction memory: receives a byte stream over a valid/ready link and assembles 16-bit instruction words.
- Writes the words into the instruction memory at consecutive addresses from 0, which the fetch stage then reads by pc.
- Holds the core in reset (cpu_hold) until a program has loaded with a correct checksum.
- Frame format: LEN_HI, LEN_LO (word count N, big-endian), then N words as HI byte then LO byte, then one CHK byte equal to the XOR of all 2N data bytes.

---
 rtl/imem_loader_pkg.sv | 19 +
 rtl/imem_loader_byte_assembler.sv | 34 +++
 rtl/imem_loader.sv | 145 ++++++++++++++
 tb/tb_imem_loader.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader and the fetch stage.
package imem_loader_pkg;

    localparam int unsigned BYTE_W      = 8;
    localparam int unsigned IMEM_ADDR_W = 16;
    localparam int unsigned IMEM_DATA_W = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA_HI,
        S_DATA_LO,
        S_CHK,
        S_DONE,
        S_ERR
    } state_t;

endpackage

// File: rtl/imem_loader_byte_assembler.sv
// Pairs HI/LO bytes into an instruction word and keeps the running XOR checksum.
module imem_loader_byte_assembler
    import imem_loader_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                clear,
    input  logic                hi_en,
    input  logic                lo_en,
    input  logic [BYTE_W-1:0]   data,
    output logic [BYTE_W-1:0]   csum,
    output logic [2*BYTE_W-1:0] word
);

    logic [BYTE_W-1:0] hi;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi   <= '0;
            csum <= '0;
        end else if (clear) begin
            csum <= '0;
        end else begin
            if (hi_en)
                hi <= data;
            if (hi_en || lo_en)
                csum <= csum ^ data;
        end
    end

    // LO byte is taken straight from the bus so the word is ready on the accepting edge.
    assign word = {hi, data};

endmodule

// File: rtl/imem_loader.sv
// Byte-stream loader: parses a length/data/checksum frame and writes 16-bit words to instruction memory.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned ADDR_W = IMEM_ADDR_W,
    parameter int unsigned DATA_W = IMEM_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [BYTE_W-1:0] rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              cpu_hold
);

    state_t              state, state_next;
    logic [15:0]         len;
    logic [15:0]         len_full;
    logic [ADDR_W:0]     count;
    logic                xfer;
    logic                idle_like;
    logic                overflow;
    logic                last_word;
    logic [BYTE_W-1:0]   csum;
    logic [2*BYTE_W-1:0] word;

    assign xfer      = rx_valid && rx_ready;
    assign idle_like = (state == S_IDLE) || (state == S_DONE) || (state == S_ERR);
    assign len_full  = {len[15:8], rx_data};
    assign overflow  = 33'(len_full) > (33'(1) << ADDR_W);
    assign last_word = (33'(count) + 33'd1) == 33'(len);

    imem_loader_byte_assembler u_asm (
        .clk   (clk),
        .reset (reset),
        .clear (idle_like && start),
        .hi_en (xfer && (state == S_DATA_HI)),
        .lo_en (xfer && (state == S_DATA_LO)),
        .data  (rx_data),
        .csum  (csum),
        .word  (word)
    );

    always_comb begin
        rx_ready = 1'b0;
        case (state)
            S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO, S_CHK: rx_ready = 1'b1;
            default: rx_ready = 1'b0;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE, S_DONE, S_ERR: if (start) state_next = S_LEN_HI;
            S_LEN_HI:  if (xfer) state_next = S_LEN_LO;
            S_LEN_LO: begin
                if (xfer) begin
                    if (len_full == '0)
                        state_next = S_CHK;
                    else if (overflow)
                        state_next = S_ERR;
                    else
                        state_next = S_DATA_HI;
                end
            end
            S_DATA_HI: if (xfer) state_next = S_DATA_LO;
            S_DATA_LO: if (xfer) state_next = last_word ? S_CHK : S_DATA_HI;
            S_CHK:     if (xfer) state_next = (rx_data == csum) ? S_DONE : S_ERR;
            default:   state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= S_IDLE;
        else
            state <= state_next;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            len       <= '0;
            count     <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            cpu_hold  <= 1'b1;
        end else begin
            mem_we <= 1'b0;
            case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        busy     <= 1'b1;
                        done     <= 1'b0;
                        err      <= 1'b0;
                        cpu_hold <= 1'b1;
                        count    <= '0;
                    end
                end
                S_LEN_HI: if (xfer) len[15:8] <= rx_data;
                S_LEN_LO: begin
                    if (xfer) begin
                        len[7:0] <= rx_data;
                        if ((len_full != '0) && overflow) begin
                            busy <= 1'b0;
                            err  <= 1'b1;
                        end
                    end
                end
                S_DATA_LO: begin
                    if (xfer) begin
                        mem_we    <= 1'b1;
                        mem_addr  <= count[ADDR_W-1:0];
                        mem_wdata <= DATA_W'(word);
                        count     <= count + (ADDR_W+1)'(1);
                    end
                end
                S_CHK: begin
                    if (xfer) begin
                        busy <= 1'b0;
                        if (rx_data == csum) begin
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader with a frame-level reference model and a shadow instruction memory.
module tb_imem_loader;
    import imem_loader_pkg::*;

    localparam int unsigned AW    = 4;
    localparam int unsigned DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [7:0]    rx_data = '0;
    logic          rx_valid = 1'b0;
    logic          rx_ready, mem_we, busy, done, err, cpu_hold;
    logic [AW-1:0] mem_addr;
    logic [15:0]   mem_wdata;

    imem_loader #(.ADDR_W(AW), .DATA_W(16)) dut (
        .clk(clk), .reset(reset), .start(start),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .busy(busy), .done(done), .err(err), .cpu_hold(cpu_hold)
    );

    always #5 clk = ~clk;

    int unsigned errors = 0;
    int unsigned checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    logic [7:0]   tx_q[$];
    int unsigned  cur_n = 0;
    int unsigned  frame_pos = 0;
    logic [15:0]  model_mem [DEPTH];
    logic [15:0]  imem [DEPTH];

    // Monitor: a LO data byte accepted on an edge must show up as a write on the next edge.
    logic          exp_we = 1'b0;
    logic [AW-1:0] exp_addr = '0;
    logic [15:0]   exp_data = '0;

    always @(negedge clk) begin
        if (mem_we || exp_we) begin
            check("mem_we", mem_we, exp_we);
            if (exp_we) begin
                check("mem_addr", mem_addr, exp_addr);
                check("mem_wdata", mem_wdata, exp_data);
            end
        end
        if (mem_we)
            imem[mem_addr] = mem_wdata;
        exp_we = 1'b0;
        if (reset && rx_valid && rx_ready) begin
            if (frame_pos >= 3 && frame_pos < 2 + 2 * cur_n && frame_pos % 2 == 1) begin
                exp_we   = 1'b1;
                exp_addr = AW'((frame_pos - 3) / 2);
                exp_data = {tx_q[frame_pos - 1], tx_q[frame_pos]};
            end
            frame_pos++;
        end
    end

    function automatic int unsigned frame_len();
        return {tx_q[0], tx_q[1]};
    endfunction

    function automatic logic frame_ok();
        int unsigned n;
        logic [7:0]  x;
        n = frame_len();
        x = '0;
        if (n > DEPTH) return 1'b0;
        for (int i = 0; i < 2 * n; i++) x ^= tx_q[2 + i];
        return x == tx_q[2 + 2 * n];
    endfunction

    task automatic build_frame(input int unsigned n, input bit good);
        logic [7:0] x;
        logic [7:0] b;
        x = '0;
        tx_q.delete();
        tx_q.push_back(n[15:8]);
        tx_q.push_back(n[7:0]);
        if (n > DEPTH) return;
        for (int i = 0; i < 2 * n; i++) begin
            b = 8'($urandom);
            tx_q.push_back(b);
            x ^= b;
        end
        tx_q.push_back(good ? x : (x ^ 8'($urandom_range(1, 255))));
    endtask

    task automatic check_reset_values();
        check("rst_rx_ready", rx_ready, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_cpu_hold", cpu_hold, 1);
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("start_busy", busy, 1);
        check("start_cpu_hold", cpu_hold, 1);
        check("start_done", done, 0);
        check("start_err", err, 0);
        check("start_rx_ready", rx_ready, 1);
    endtask

    task automatic send_frame(input bit throttle, input int start_at, input int stop_after,
                              output int unsigned cycles);
        int unsigned wait_n;
        int unsigned gap;
        cycles    = 0;
        frame_pos = 0;
        for (int k = 0; k < tx_q.size(); k++) begin
            if (throttle) begin
                gap = $urandom_range(0, 2);
                rx_valid = 1'b0;
                repeat (gap) begin
                    @(posedge clk); #1;
                    cycles++;
                    check("ready_while_idle_src", rx_ready, busy);
                end
            end
            rx_data  = tx_q[k];
            rx_valid = 1'b1;
            start    = (k == start_at);
            wait_n   = 0;
            while (!rx_ready && wait_n < 50) begin
                @(posedge clk); #1;
                wait_n++;
                cycles++;
            end
            if (!rx_ready) begin
                check("rx_ready_timeout", rx_ready, 1);
                rx_valid = 1'b0;
                start    = 1'b0;
                return;
            end
            @(posedge clk); #1;
            cycles++;
            start = 1'b0;
            if (k == stop_after) begin
                rx_valid = 1'b0;
                return;
            end
        end
        rx_valid = 1'b0;
    endtask

    task automatic run_frame(input bit throttle, input int start_at);
        int unsigned cyc;
        int unsigned n;
        logic        ok;
        ok    = frame_ok();
        n     = frame_len();
        cur_n = n;
        do_start();
        send_frame(throttle, start_at, -1, cyc);
        if (!throttle) check("no_bubbles", cyc, tx_q.size());
        check("end_busy", busy, 0);
        check("end_done", done, ok);
        check("end_err", err, !ok);
        check("end_cpu_hold", cpu_hold, !ok);
        check("end_rx_ready", rx_ready, 0);
        if (n <= DEPTH)
            for (int i = 0; i < n; i++) model_mem[i] = {tx_q[2 + 2 * i], tx_q[3 + 2 * i]};
        @(negedge clk); @(negedge clk);
        check("no_late_write", mem_we, 0);
        for (int i = 0; i < DEPTH; i++) check("imem_content", imem[i], model_mem[i]);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1);
    end

    initial begin
        int unsigned cyc;
        for (int i = 0; i < DEPTH; i++) begin
            imem[i]      = '0;
            model_mem[i] = '0;
        end
        #12;
        check_reset_values();
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        check_reset_values();

        tx_q = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40};
        run_frame(1'b0, -1);
        tx_q = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h41};
        run_frame(1'b0, -1);
        tx_q = '{8'h00, 8'h00, 8'h00};
        run_frame(1'b0, -1);
        tx_q = '{8'h00, 8'h00, 8'h01};
        run_frame(1'b0, -1);
        tx_q = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40};
        run_frame(1'b1, -1);
        tx_q = '{8'h00, 8'h02, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'h56 ^ 8'h78 ^ 8'h9A ^ 8'hBC};
        run_frame(1'b0, 3);

        // Asynchronous reset right after the 3rd data byte; word 0 stays written.
        build_frame(3, 1'b1);
        cur_n = 3;
        do_start();
        send_frame(1'b0, -1, 4, cyc);
        reset = 1'b0;
        #2;
        check_reset_values();
        model_mem[0] = {tx_q[2], tx_q[3]};
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        check("abort_word0", imem[0], model_mem[0]);
        build_frame(5, 1'b1);
        run_frame(1'b0, -1);

        build_frame(DEPTH, 1'b1);
        run_frame(1'b1, -1);
        build_frame(DEPTH + 1, 1'b1);
        run_frame(1'b0, -1);

        for (int f = 0; f < 10; f++) begin
            build_frame($urandom_range(0, DEPTH), $urandom_range(0, 3) != 0);
            run_frame(1'($urandom_range(0, 1)), -1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
